// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC APB initiator: job states, write-sequence steps,
// slave register offsets and CTRL mode encodings.
package ecc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        ACCESS    = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        STEP_DATA  = 3'd0,
        STEP_RDBK  = 3'd1,
        STEP_WIDTH = 3'd2,
        STEP_NOISE = 3'd3,
        STEP_CTRL  = 3'd4
    } step_e;

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_DATA_IN = 8'h04;
    localparam logic [7:0] OFF_WIDTH   = 8'h08;
    localparam logic [7:0] OFF_NOISE   = 8'h0C;

    localparam logic [1:0] MODE_ENC = 2'd0;
    localparam logic [1:0] MODE_DEC = 2'd1;
    localparam logic [1:0] MODE_FC  = 2'd2;

    // Full-channel and the reserved mode both carry a NOISE write.
    function automatic logic mode_has_noise(input logic [1:0] mode);
        return (mode >= MODE_FC);
    endfunction

endpackage

// File: rtl/ecc_apb_master_if.sv
// Bundle of the command, APB, slave-result and response signals of the ECC APB initiator.
interface ecc_apb_master_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32
) ();

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_mode;
    logic [1:0]                 cmd_width;
    logic [AMBA_WORD-1:0]       cmd_data;
    logic [AMBA_WORD-1:0]       cmd_noise;

    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;

    logic                       operation_done;
    logic [DATA_WIDTH-1:0]      data_out;
    logic [1:0]                 num_of_errors;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [DATA_WIDTH-1:0]      rsp_data;
    logic [1:0]                 rsp_errors;
    logic                       rsp_timeout;
    logic                       rsp_rdbk_err;

    modport master (
        input  cmd_valid, cmd_mode, cmd_width, cmd_data, cmd_noise,
        output cmd_ready,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA,
        input  operation_done, data_out, num_of_errors,
        output rsp_valid, rsp_data, rsp_errors, rsp_timeout, rsp_rdbk_err,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_width, cmd_data, cmd_noise,
        input  cmd_ready,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA,
        output operation_done, data_out, num_of_errors,
        input  rsp_valid, rsp_data, rsp_errors, rsp_timeout, rsp_rdbk_err,
        output rsp_ready
    );

endinterface

// File: rtl/ecc_apb_master_apb_xfer_seq.sv
// Two-cycle APB SETUP/ACCESS driver; a start pulse loads address/data and opens a transfer,
// and a start during ACCESS chains the next transfer with PSEL held high.
module apb_xfer_seq #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       xfer_start,
    input  logic [AMBA_ADDR_WIDTH-1:0] xfer_addr,
    input  logic [AMBA_WORD-1:0]       xfer_wdata,
    input  logic                       xfer_write,
    output logic                       xfer_done,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [AMBA_ADDR_WIDTH-1:0] paddr,
    output logic [AMBA_WORD-1:0]       pwdata
);

    logic                       psel_r;
    logic                       penable_r;
    logic                       pwrite_r;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_r;
    logic [AMBA_WORD-1:0]       pwdata_r;

    // APB phase registers; address and data hold their last values between transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {AMBA_ADDR_WIDTH{1'b0}};
            pwdata_r  <= {AMBA_WORD{1'b0}};
        end else if (xfer_start) begin
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            pwrite_r  <= xfer_write;
            paddr_r   <= xfer_addr;
            pwdata_r  <= xfer_wdata;
        end else if (psel_r && !penable_r) begin
            penable_r <= 1'b1;
        end else begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
        end
    end

    assign xfer_done = psel_r & penable_r;
    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign paddr     = paddr_r;
    assign pwdata    = pwdata_r;

endmodule

// File: rtl/ecc_apb_master.sv
// APB initiator running one ECC job per command: register writes, wait for completion, respond.
// Optional DATA_IN readback check enabled by defining ECC_APB_MASTER_READBACK_CHECK_EN.
module ecc_apb_master
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int DONE_TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          rst,
    ecc_apb_master_if.master bus
);

    localparam int CNT_W = $clog2(DONE_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

    state_e                     state_r, state_next_s;
    step_e                      step_r, step_next_s, nstep_s;
    logic [1:0]                 mode_r, width_r;
    logic [AMBA_WORD-1:0]       data_r, noise_r;
    logic [CNT_W-1:0]           cnt_r;
    logic                       cmd_ready_r, rsp_valid_r, rsp_timeout_r;
    logic [DATA_WIDTH-1:0]      rsp_data_r;
    logic [1:0]                 rsp_errors_r;

    logic                       accept_s, capture_done_s, capture_to_s;
    logic                       xfer_start_s, xfer_write_s, xfer_done_s;
    logic [AMBA_ADDR_WIDTH-1:0] xfer_addr_s, step_addr_s;
    logic [AMBA_WORD-1:0]       xfer_wdata_s, step_wdata_s;
    logic                       step_write_s;
    logic                       psel_s, penable_s, pwrite_s;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_s;
    logic [AMBA_WORD-1:0]       pwdata_s;

    function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input logic [7:0] off);
        return {{(AMBA_ADDR_WIDTH-8){1'b0}}, off};
    endfunction

    function automatic logic [AMBA_WORD-1:0] zext2(input logic [1:0] v);
        return {{(AMBA_WORD-2){1'b0}}, v};
    endfunction

    // CTRL must stay last: the slave starts the operation when CTRL is written.
    function automatic step_e next_step(input step_e cur, input logic [1:0] mode);
        step_e nxt;
        case (cur)
`ifdef ECC_APB_MASTER_READBACK_CHECK_EN
            STEP_DATA:  nxt = STEP_RDBK;
`else
            STEP_DATA:  nxt = STEP_WIDTH;
`endif
            STEP_RDBK:  nxt = STEP_WIDTH;
            STEP_WIDTH: nxt = mode_has_noise(mode) ? STEP_NOISE : STEP_CTRL;
            STEP_NOISE: nxt = STEP_CTRL;
            default:    nxt = STEP_CTRL;
        endcase
        return nxt;
    endfunction

    assign nstep_s = next_step(step_r, mode_r);

    // Address, data and direction of the step that follows the current one
    always_comb begin
        step_addr_s  = reg_addr(OFF_CTRL);
        step_wdata_s = zext2(mode_r);
        step_write_s = 1'b1;
        case (nstep_s)
            STEP_DATA: begin
                step_addr_s  = reg_addr(OFF_DATA_IN);
                step_wdata_s = data_r;
            end
            STEP_RDBK: begin
                step_addr_s  = reg_addr(OFF_DATA_IN);
                step_wdata_s = data_r;
                step_write_s = 1'b0;
            end
            STEP_WIDTH: begin
                step_addr_s  = reg_addr(OFF_WIDTH);
                step_wdata_s = zext2(width_r);
            end
            STEP_NOISE: begin
                step_addr_s  = reg_addr(OFF_NOISE);
                step_wdata_s = noise_r;
            end
            default: begin
                step_addr_s  = reg_addr(OFF_CTRL);
                step_wdata_s = zext2(mode_r);
            end
        endcase
    end

    // Job FSM next state and per-cycle control strobes
    always_comb begin
        state_next_s   = state_r;
        step_next_s    = step_r;
        accept_s       = 1'b0;
        capture_done_s = 1'b0;
        capture_to_s   = 1'b0;
        xfer_start_s   = 1'b0;
        xfer_addr_s    = step_addr_s;
        xfer_wdata_s   = step_wdata_s;
        xfer_write_s   = step_write_s;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_r) begin
                    accept_s     = 1'b1;
                    xfer_start_s = 1'b1;
                    xfer_addr_s  = reg_addr(OFF_DATA_IN);
                    xfer_wdata_s = bus.cmd_data;
                    xfer_write_s = 1'b1;
                    step_next_s  = STEP_DATA;
                    state_next_s = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: state_next_s = ACCESS;
            ACCESS: begin
                if (!xfer_done_s) begin
                    state_next_s = ACCESS;
                end else if (step_r == STEP_CTRL) begin
                    state_next_s = WAIT_DONE;
                end else begin
                    xfer_start_s = 1'b1;
                    step_next_s  = nstep_s;
                    state_next_s = SETUP;
                end
            end
            WAIT_DONE: begin
                if (bus.operation_done) begin
                    capture_done_s = 1'b1;
                    state_next_s   = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    capture_to_s   = 1'b1;
                    state_next_s   = RESP;
                end else begin
                    state_next_s   = WAIT_DONE;
                end
            end
            RESP: begin
                if (rsp_valid_r && bus.rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, latched command, timeout counter and registered response/handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            step_r        <= STEP_DATA;
            mode_r        <= 2'd0;
            width_r       <= 2'd0;
            data_r        <= {AMBA_WORD{1'b0}};
            noise_r       <= {AMBA_WORD{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            cmd_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= {DATA_WIDTH{1'b0}};
            rsp_errors_r  <= 2'd0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            step_r      <= step_next_s;
            cmd_ready_r <= (state_next_s == IDLE);
            rsp_valid_r <= (state_next_s == RESP);
            if (accept_s) begin
                mode_r  <= bus.cmd_mode;
                width_r <= bus.cmd_width;
                data_r  <= bus.cmd_data;
                noise_r <= bus.cmd_noise;
            end
            if (state_r == WAIT_DONE) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            if (capture_done_s) begin
                rsp_data_r    <= bus.data_out;
                rsp_errors_r  <= bus.num_of_errors;
                rsp_timeout_r <= 1'b0;
            end else if (capture_to_s) begin
                rsp_data_r    <= {DATA_WIDTH{1'b0}};
                rsp_errors_r  <= 2'd0;
                rsp_timeout_r <= 1'b1;
            end
        end
    end

`ifdef ECC_APB_MASTER_READBACK_CHECK_EN
    logic rdbk_err_r;

    // Sticky per-job readback mismatch flag, compared in the read ACCESS cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rdbk_err_r <= 1'b0;
        end else if (accept_s) begin
            rdbk_err_r <= 1'b0;
        end else if (state_r == ACCESS && step_r == STEP_RDBK && bus.PRDATA != data_r) begin
            rdbk_err_r <= 1'b1;
        end
    end

    assign bus.rsp_rdbk_err = rdbk_err_r;
`else
    logic unused_prdata_s;
    assign unused_prdata_s  = ^bus.PRDATA;
    assign bus.rsp_rdbk_err = 1'b0;
`endif

    apb_xfer_seq #(
        .AMBA_WORD      (AMBA_WORD),
        .AMBA_ADDR_WIDTH(AMBA_ADDR_WIDTH)
    ) u_xfer (
        .clk       (clk),
        .rst       (rst),
        .xfer_start(xfer_start_s),
        .xfer_addr (xfer_addr_s),
        .xfer_wdata(xfer_wdata_s),
        .xfer_write(xfer_write_s),
        .xfer_done (xfer_done_s),
        .psel      (psel_s),
        .penable   (penable_s),
        .pwrite    (pwrite_s),
        .paddr     (paddr_s),
        .pwdata    (pwdata_s)
    );

    assign bus.PSEL        = psel_s;
    assign bus.PENABLE     = penable_s;
    assign bus.PWRITE      = pwrite_s;
    assign bus.PADDR       = paddr_s;
    assign bus.PWDATA      = pwdata_s;
    assign bus.cmd_ready   = cmd_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_data    = rsp_data_r;
    assign bus.rsp_errors  = rsp_errors_r;
    assign bus.rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_ecc_apb_master.sv
// Scoreboard bench for ecc_apb_master: expected APB transfers and responses are queued per job
// and checked by independent monitors against a small behavioural ECC slave.
module tb_ecc_apb_master;

    localparam int AW  = 32;
    localparam int ADW = 20;
    localparam int DW  = 32;
    localparam int DT  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ecc_apb_master_if #(.AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW)) bus ();

    ecc_apb_master #(
        .AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW), .DONE_TIMEOUT(DT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct { logic [ADW-1:0] addr; logic [AW-1:0] data; logic wr; int off; } apb_t;
    typedef struct { logic [DW-1:0] data; logic [1:0] err; logic to; logic rd; int lat; } rsp_t;
    apb_t apb_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic rsp_seen = 1'b0;

    logic           s_done_en = 1'b0;
    logic [DW-1:0]  s_data = '0;
    logic [1:0]     s_err = 2'd0;
    logic           s_corrupt = 1'b0;
    logic [AW-1:0]  slv_data_in = '0;
    int             cdn = 0;
    logic           stray = 1'b0;

    assign bus.PRDATA = s_corrupt ? 32'hDEADBEEF : slv_data_in;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // APB monitor and slave register capture
    initial begin
        apb_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
            if (!rst && bus.PSEL && bus.PENABLE) begin
                if (bus.PWRITE && bus.PADDR == 20'h4) slv_data_in = bus.PWDATA;
                if (bus.PWRITE && bus.PADDR == 20'h0 && s_done_en) cdn = 2;
                if (apb_q.size() == 0) begin
                    chk("apb_unexpected", 64'd1, 64'd0);
                end else begin
                    e = apb_q.pop_front();
                    chk("apb_addr", 64'(bus.PADDR), 64'(e.addr));
                    chk("apb_write", 64'(bus.PWRITE), 64'(e.wr));
                    if (e.wr) chk("apb_wdata", 64'(bus.PWDATA), 64'(e.data));
                    chk("apb_cycle", 64'(cyc - acc_cyc), 64'(e.off));
                end
            end
        end
    end

    // Slave completion pulse, two cycles after the CTRL ACCESS
    initial begin
        bus.operation_done = 1'b0;
        bus.data_out = '0;
        bus.num_of_errors = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.operation_done = 1'b0;
            if (stray) begin
                bus.operation_done = 1'b1;
                stray = 1'b0;
            end
            if (cdn > 0) begin
                cdn--;
                if (cdn == 0) begin
                    bus.operation_done = 1'b1;
                    bus.data_out = s_data;
                    bus.num_of_errors = s_err;
                end
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = rsp_q[0];
                    if (!rsp_seen) begin
                        chk("rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
                        rsp_seen = 1'b1;
                    end
                    chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                    chk("rsp_errors", 64'(bus.rsp_errors), 64'(e.err));
                    chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.to));
                    chk("rsp_rdbk_err", 64'(bus.rsp_rdbk_err), 64'(e.rd));
                    chk("cmd_ready_in_resp", 64'(bus.cmd_ready), 64'd0);
                    if (bus.rsp_ready) begin
                        void'(rsp_q.pop_front());
                        rsp_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic push_apb(input logic [ADW-1:0] a, input logic [AW-1:0] d, input logic w,
                            input int off);
        apb_t e;
        e.addr = a; e.data = d; e.wr = w; e.off = off;
        apb_q.push_back(e);
    endtask

    task automatic run_job(input logic [1:0] mode, input logic [1:0] width,
                           input logic [AW-1:0] data, input logic [AW-1:0] noise,
                           input logic done_en, input logic [DW-1:0] sd, input logic [1:0] se,
                           input logic corrupt, input int hold);
        rsp_t r;
        int off;
        int n;
        off = 2;
        push_apb(20'h4, data, 1'b1, off);
`ifdef ECC_APB_MASTER_READBACK_CHECK_EN
        off += 2;
        push_apb(20'h4, data, 1'b0, off);
        r.rd = corrupt;
`else
        r.rd = 1'b0;
`endif
        off += 2;
        push_apb(20'h8, {30'd0, width}, 1'b1, off);
        if (mode[1]) begin
            off += 2;
            push_apb(20'hC, noise, 1'b1, off);
        end
        off += 2;
        push_apb(20'h0, {30'd0, mode}, 1'b1, off);
        r.data = done_en ? sd : '0;
        r.err  = done_en ? se : 2'd0;
        r.to   = ~done_en;
        r.lat  = done_en ? off + 3 : off + 1 + DT;
        rsp_q.push_back(r);
        s_done_en = done_en; s_data = sd; s_err = se; s_corrupt = corrupt;

        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_mode = mode; bus.cmd_width = width;
        bus.cmd_data = data; bus.cmd_noise = noise;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.cmd_ready) chk("cmd_accept_bound", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;

        n = 0;
        while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (!bus.rsp_valid) chk("rsp_valid_bound", 64'd0, 64'd1);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rsp", 64'(bus.cmd_ready), 64'd1);
        chk("rsp_valid_after_rsp", 64'(bus.rsp_valid), 64'd0);
        s_corrupt = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_mode = 2'd0; bus.cmd_width = 2'd0;
        bus.cmd_data = '0; bus.cmd_noise = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_psel", 64'(bus.PSEL), 64'd0);
        chk("reset_penable", 64'(bus.PENABLE), 64'd0);
        chk("reset_pwrite", 64'(bus.PWRITE), 64'd0);
        chk("reset_paddr", 64'(bus.PADDR), 64'd0);
        chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // encode
        run_job(2'd0, 2'd1, 32'h0000_00A5, 32'h0, 1'b1, 32'h0000_01A5, 2'd0, 1'b0, 0);
        // full channel with 5 cycles of response backpressure
        run_job(2'd2, 2'd2, 32'h0000_1234, 32'h0000_0004, 1'b1, 32'h0000_5A5A, 2'd1, 1'b0, 5);
        // timeout
        run_job(2'd0, 2'd0, 32'h0000_0077, 32'h0, 1'b0, 32'hFFFF_FFFF, 2'd3, 1'b0, 0);

        // stray done in IDLE produces nothing
        stray = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stray_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end

        // decode with corrupted readback data
        run_job(2'd1, 2'd3, 32'h1234_5678, 32'h0, 1'b1, 32'h0000_0042, 2'd2, 1'b1, 0);

        // reset in the middle of the first SETUP abandons the job
        s_done_en = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_mode = 2'd0; bus.cmd_width = 2'd1;
        bus.cmd_data = 32'h0000_0055;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_setup_psel", 64'(bus.PSEL), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_abort_psel", 64'(bus.PSEL), 64'd0);
        chk("rst_abort_penable", 64'(bus.PENABLE), 64'd0);
        chk("rst_abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        repeat (20) @(negedge clk);

        // reserved mode after reset: noise write, CTRL written as-is
        run_job(2'd3, 2'd0, 32'hCAFE_0001, 32'h8000_0001, 1'b1, 32'h0BAD_F00D, 2'd0, 1'b0, 1);

        repeat (5) @(negedge clk);
        chk("apb_queue_drained", 64'(apb_q.size()), 64'd0);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
